// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: forwarding selects, load-use stall, branch flush, data-memory freeze, perf counters.
// Controls are combinational from the current pipeline fields; only the freeze FSM and counters are registered.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_LAT    = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [REG_ADDR_W-1:0] Id_Rs,
    input  logic [REG_ADDR_W-1:0] Id_Rt,
    input  logic                  Id_UsesRt,
    input  logic [REG_ADDR_W-1:0] Ex_Rs,
    input  logic [REG_ADDR_W-1:0] Ex_Rt,
    input  logic                  Ex_MemRead,
    input  logic [REG_ADDR_W-1:0] Mem_Rd,
    input  logic                  Mem_RegWrite,
    input  logic                  Mem_MemRead,
    input  logic                  Mem_MemWrite,
    input  logic                  Mem_PCSrc,
    input  logic [REG_ADDR_W-1:0] Wb_Rd,
    input  logic                  Wb_RegWrite,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic                  Control_Unit_Sel,
    output logic                  Flush,
    output logic                  Freeze,
    output logic [CNT_W-1:0]      Stall_Count,
    output logic [CNT_W-1:0]      Flush_Count
);

    localparam logic [3:0] WAIT_LOAD = 4'((MEM_LAT >= 2) ? (MEM_LAT - 2) : 0);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic             w_freeze_fsm;
    logic             w_freeze;
    logic             w_flush;
    logic             w_load_use;
    logic             w_stall;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // MEM has priority over WB so the youngest producer wins; $zero is never forwarded.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (Mem_RegWrite && Mem_Rd != '0 && Mem_Rd == Ex_Rs)
            w_fwd_a = 2'b10;
        else if (Wb_RegWrite && Wb_Rd != '0 && Wb_Rd == Ex_Rs)
            w_fwd_a = 2'b01;
        if (Mem_RegWrite && Mem_Rd != '0 && Mem_Rd == Ex_Rt)
            w_fwd_b = 2'b10;
        else if (Wb_RegWrite && Wb_Rd != '0 && Wb_Rd == Ex_Rt)
            w_fwd_b = 2'b01;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_freeze_fsm = 1'b0;
        if (MEM_LAT > 1) begin
            case (r_state)
                S_IDLE: begin
                    if (Mem_MemRead || Mem_MemWrite) begin
                        w_freeze_fsm = 1'b1;
                        w_cnt_nxt    = WAIT_LOAD;
                        w_state_nxt  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        w_freeze_fsm = 1'b1;
                        w_cnt_nxt    = r_cnt - 4'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Freeze outranks flush, flush outranks the load-use bubble.
    assign w_freeze   = RST && w_freeze_fsm;
    assign w_flush    = RST && Mem_PCSrc && !w_freeze;
    assign w_load_use = Ex_MemRead && Ex_Rt != '0 &&
                        (Ex_Rt == Id_Rs || (Id_UsesRt && Ex_Rt == Id_Rt));
    assign w_stall    = RST && w_load_use && !w_freeze && !w_flush;

    assign ForwardA         = RST ? w_fwd_a : 2'b00;
    assign ForwardB         = RST ? w_fwd_b : 2'b00;
    assign Freeze           = w_freeze;
    assign Flush            = w_flush;
    assign PCWrite          = !(w_freeze || w_stall);
    assign IF_ID_Write      = !(w_freeze || w_stall);
    assign Control_Unit_Sel = w_flush || w_stall;
    assign Stall_Count      = r_stall_cnt;
    assign Flush_Count      = r_flush_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if ((w_freeze || w_stall) && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

endmodule
